// File: rtl/dcnt_pkg.sv
// Shared constants and types for the down_count_timer block.
package dcnt_pkg;

   localparam int unsigned DCNT_WIDTH_DEF = 4;

   // Behaviour applied when an enabled count reaches zero
   typedef enum logic {
      MODE_RELOAD  = 1'b0,
      MODE_ONESHOT = 1'b1
   } mode_e;

   function automatic mode_e sel_mode(input logic oneshot);
      return oneshot ? MODE_ONESHOT : MODE_RELOAD;
   endfunction

endpackage

// File: rtl/down_count_timer_zero_detect.sv
// All-zero detector for the count register; drives the zero level and the cascade carry.
module zero_detect #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] d,
   output logic             zero
);

   assign zero = ~|d;

endmodule

// File: rtl/down_count_timer.sv
// Loadable down counter/timer with reload limit, carry-out and terminal-count pulse.
// Define DCNT_ONESHOT_EN to add the oneshot port and the sticky done flag.
module down_count_timer
   import dcnt_pkg::*;
#(
   parameter int unsigned WIDTH = DCNT_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] l,
`ifdef DCNT_ONESHOT_EN
   input  logic             oneshot,
`endif
   output logic [WIDTH-1:0] d,
   output logic             zero,
   output logic             co,
   output logic             tc,
   output logic             done
);

   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] d_nxt;
   logic             tc_q;
   logic             tc_nxt;
   logic             done_q;
   mode_e            mode;

`ifdef DCNT_ONESHOT_EN
   logic             done_nxt;
   assign mode = sel_mode(oneshot);
`else
   assign done_q = 1'b0;
   assign mode   = MODE_RELOAD;
`endif

   zero_detect #(
      .WIDTH (WIDTH)
   ) u_zero_detect (
      .d    (d_q),
      .zero (zero)
   );

   // Next-state selection: load beats enable; the zero branch replaces underflow
   always_comb begin
      d_nxt  = d_q;
      tc_nxt = 1'b0;
`ifdef DCNT_ONESHOT_EN
      done_nxt = done_q;
`endif
      if (load) begin
         d_nxt = b;
`ifdef DCNT_ONESHOT_EN
         done_nxt = 1'b0;
`endif
      end else if (en && !done_q) begin
         if (!zero) begin
            d_nxt = d_q - WIDTH'(1);
         end else begin
            case (mode)
               MODE_RELOAD: begin
                  d_nxt  = l;
                  tc_nxt = 1'b1;
               end
               MODE_ONESHOT: begin
                  d_nxt  = d_q;
                  tc_nxt = 1'b1;
`ifdef DCNT_ONESHOT_EN
                  done_nxt = 1'b1;
`endif
               end
               default: begin
                  d_nxt  = d_q;
                  tc_nxt = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q  <= '0;
         tc_q <= 1'b0;
      end else begin
         d_q  <= d_nxt;
         tc_q <= tc_nxt;
      end
   end

`ifdef DCNT_ONESHOT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_nxt;
      end
   end
`endif

   // Carry is combinational so a cascaded stage sees it in the same cycle
   assign co   = en & ~load & zero & ~done_q;
   assign d    = d_q;
   assign tc   = tc_q;
   assign done = done_q;

endmodule

// File: tb/tb_down_count_timer.sv
// Scoreboard bench for down_count_timer (WIDTH=4); one-shot vectors run when DCNT_ONESHOT_EN is defined.
module tb_down_count_timer;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         load;
   logic [W-1:0] b;
   logic [W-1:0] l;
`ifdef DCNT_ONESHOT_EN
   logic         oneshot;
`endif
   logic [W-1:0] d;
   logic         zero;
   logic         co;
   logic         tc;
   logic         done;

   typedef struct {
      string        name;
      logic [W-1:0] d;
      logic         zero;
      logic         co;
      logic         tc;
      logic         done;
   } exp_t;

   exp_t sb[$];
   event chk_now;
   int   checks = 0;
   int   errors = 0;

   down_count_timer #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .load    (load),
      .b       (b),
      .l       (l),
`ifdef DCNT_ONESHOT_EN
      .oneshot (oneshot),
`endif
      .d       (d),
      .zero    (zero),
      .co      (co),
      .tc      (tc),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare presented outputs against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or chk_now);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({d, zero, co, tc, done} !== {e.d, e.zero, e.co, e.tc, e.done}) begin
               errors++;
               $display("FAIL %s: got d=%0d zero=%0b co=%0b tc=%0b done=%0b, want d=%0d zero=%0b co=%0b tc=%0b done=%0b",
                        e.name, d, zero, co, tc, done, e.d, e.zero, e.co, e.tc, e.done);
            end
         end
      end
   end

   function automatic void expect_out(input string nm, input logic [W-1:0] ed,
                                      input logic eco, input logic etc, input logic edn);
      exp_t e;
      e.name = nm;
      e.d    = ed;
      e.zero = (ed == '0);
      e.co   = eco;
      e.tc   = etc;
      e.done = edn;
      sb.push_back(e);
   endfunction

   // One cycle: inputs for this cycle, and the outputs expected during it
   task automatic cyc(input logic e_en, input logic e_ld, input logic [W-1:0] bv,
                      input logic [W-1:0] lv, input logic [W-1:0] ed, input logic eco,
                      input logic etc, input logic edn, input string nm);
      @(posedge clk);
      #1;
      en   = e_en;
      load = e_ld;
      b    = bv;
      l    = lv;
      expect_out(nm, ed, eco, etc, edn);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      load  = 1'b0;
      b     = '0;
      l     = '0;
`ifdef DCNT_ONESHOT_EN
      oneshot = 1'b0;
`endif

      cyc(0, 0, 0, 0, 0, 0, 0, 0, "reset_state");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, "reset_hold");
      rst_n = 1'b1;

      // Count and wrap with l=9 from b=5
      cyc(0, 1, 5, 9, 0, 0, 0, 0, "load5_pending");
      cyc(1, 0, 5, 9, 5, 0, 0, 0, "count_d5");
      cyc(1, 0, 5, 9, 4, 0, 0, 0, "count_d4");
      cyc(1, 0, 5, 9, 3, 0, 0, 0, "count_d3");
      cyc(1, 0, 5, 9, 2, 0, 0, 0, "count_d2");
      cyc(1, 0, 5, 9, 1, 0, 0, 0, "count_d1");
      cyc(1, 0, 5, 9, 0, 1, 0, 0, "count_d0_co");
      cyc(1, 0, 5, 9, 9, 0, 1, 0, "wrap_to_l_tc");
      for (int v = 8; v >= 1; v--) cyc(1, 0, 5, 9, W'(v), 0, 0, 0, "period_count");
      cyc(1, 0, 5, 9, 0, 1, 0, 0, "period_d0_co");
      cyc(1, 0, 5, 9, 9, 0, 1, 0, "second_tc_after_10");

      // Load beats enable
      cyc(0, 1, 3, 9, 8, 0, 0, 0, "load3_pending");
      cyc(1, 1, 7, 9, 3, 0, 0, 0, "load_with_en_d3");
      cyc(0, 0, 7, 9, 7, 0, 0, 0, "load_no_decrement");

      // Degenerate limit l=0
      cyc(0, 1, 0, 0, 7, 0, 0, 0, "load0_pending");
      cyc(1, 0, 0, 0, 0, 1, 0, 0, "l0_first_enable");
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 1, 1, 0, "l0_tc_every_cycle");

      // Enable gating at zero, then wrap to l=6
      cyc(0, 0, 0, 6, 0, 0, 1, 0, "gate_last_tc");
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 6, 0, 0, 0, 0, "gate_hold_zero");
      cyc(1, 0, 0, 6, 0, 1, 0, 0, "gate_en_co");
      cyc(0, 0, 0, 6, 6, 0, 1, 0, "gate_wrap_tc");

      // Asynchronous reset mid-cycle while d=6 and tc=1
      #6;
      rst_n = 1'b0;
      #1;
      expect_out("async_reset_now", 0, 0, 0, 0);
      -> chk_now;
      cyc(0, 0, 0, 6, 0, 0, 0, 0, "reset_held");
      rst_n = 1'b1;
      cyc(0, 1, 2, 9, 0, 0, 0, 0, "post_reset_load");
      cyc(1, 0, 2, 9, 2, 0, 0, 0, "post_reset_d2");
      cyc(1, 0, 2, 9, 1, 0, 0, 0, "post_reset_d1");
      cyc(0, 0, 2, 9, 0, 0, 0, 0, "post_reset_d0_gated");

`ifdef DCNT_ONESHOT_EN
      oneshot = 1'b1;
      cyc(0, 1, 2, 3, 0, 0, 0, 0, "os_load2_pending");
      cyc(1, 0, 2, 3, 2, 0, 0, 0, "os_d2");
      cyc(1, 0, 2, 3, 1, 0, 0, 0, "os_d1");
      cyc(1, 0, 2, 3, 0, 1, 0, 0, "os_d0_co");
      cyc(1, 0, 2, 3, 0, 0, 1, 1, "os_done_tc");
      cyc(1, 0, 2, 3, 0, 0, 0, 1, "os_stop_no_tc");
      cyc(1, 0, 2, 3, 0, 0, 0, 1, "os_stop_held");
      cyc(1, 1, 1, 3, 0, 0, 0, 1, "os_reload_pending");
      cyc(1, 0, 1, 3, 1, 0, 0, 0, "os_done_cleared");
      cyc(1, 0, 1, 3, 0, 1, 0, 0, "os_resume_d0_co");
      cyc(0, 0, 1, 3, 0, 0, 1, 1, "os_second_done");
`endif

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/down_count_timer.md
# down_count_timer

Loadable, parameterised down counter/timer that counts from a loaded or reload value toward zero and wraps back to a programmable limit. It is the count-down counterpart of the team's loadable up counter. It sits in the same timing/sequencing fabric and is used for interval timers and delay generation. A combinational carry-out lets stages be cascaded, and a registered terminal-count pulse drives downstream control.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  count enable; decrement when high
- load  in  1  synchronous load of b; priority over en
- b  in  WIDTH  load value
- l  in  WIDTH  reload limit; value taken after wrap from zero
- oneshot  in  1  stop at zero instead of reloading (present only with DCNT_ONESHOT_EN)
- d  out  WIDTH  current count
- zero  out  1  level, d == 0
- co  out  1  combinational carry-out: en & ~load & (d == 0) & ~done
- tc  out  1  registered terminal-count pulse, one cycle
- done  out  1  sticky one-shot completion flag (constant 0 without DCNT_ONESHOT_EN)

## Operation
- Priority: rst_n low > load > en > hold.
- rst_n low (async): d=0, tc=0, done=0, held while low.
- load=1: d←b, tc←0, done←0; no decrement that cycle, even if en=1.
- en=1, load=0, d≠0: d←d−1, tc←0.
- en=1, load=0, d==0, not one-shot: d←l, tc←1 (wrap event).
- en=1, load=0, d==0, oneshot=1, done=0: d holds 0, done←1, tc←1.
- done=1: d holds regardless of en; co=0; no further tc; cleared only by load or rst_n.
- en=0, load=0: d holds, tc←0.
- Arithmetic is unsigned modulo 2^WIDTH. The d==0 branch replaces underflow; d never goes from 0 to all-ones.
- b > l is legal: the counter counts down from b and reloads l after the first wrap.
- l=0: every enabled cycle at zero is a wrap; d stays 0; tc is high on every cycle after the first enabled one.

## Timing
- Load latency: 1 cycle (d=b visible after the edge on which load=1).
- tc is high for exactly the cycle following the wrap edge, coincident with d==l (or d==0 in one-shot mode).
- co and zero are combinational from d/en/load/done in the same cycle. They are intended as the en of a cascaded next stage.
- Period with continuous en and no load: l+1 cycles between tc pulses.
- rst_n deassertion is effective at the next rising edge. Reset asserted mid-count discards the count immediately.

## Configuration
- DCNT_ONESHOT_EN defined: the oneshot port and done register exist, and the one-shot behaviour above applies.
- DCNT_ONESHOT_EN undefined: no oneshot port; done is tied 0; the counter always auto-reloads from l.

## Structure
- Package dcnt_pkg holds the default WIDTH constant (DCNT_WIDTH_DEF=4) and a two-value mode enum (MODE_RELOAD, MODE_ONESHOT) used for next-state selection.
- Sub-module zero_detect is a WIDTH-parameterised reduction that produces zero. Counter register, next-state mux, and tc/done flops stay in the top.

## Test plan
- Reset: run to d=6, pull rst_n low mid-cycle → d=0, tc=0, done=0 immediately, with no clock edge needed.
- Count/wrap: WIDTH=4, l=9, load b=5, then en=1 → d=5,4,3,2,1,0,9,8…; co high only in the d=0 cycle; tc high one cycle with d=9; next tc 10 cycles later.
- Load vs en: d=3, load=1, en=1, b=7 → d=7 next cycle, no decrement, tc=0.
- Degenerate limit: l=0, d=0, en held high → d stays 0, co constantly 1, tc 1 every cycle after the first enabled edge.
- Enable gating: d=0, en=0 for 4 cycles → d stays 0, co=0, tc=0; en=1 → wrap to l with tc pulse.
- One-shot (macro on): l=3, load b=2, oneshot=1, en=1 → d=2,1,0,0…; single tc pulse; done=1; co=0 afterward. Then load b=1 → done=0, d=1, counting resumes.
